branch_predictor: RTL and testbench

- Predict-side partner of the branch resolution stage: holds a table of 2-bit saturating counters indexed by PC and emits the branch_predicted bit that travels down the pipe to resolution.
- Trains its table from resolution results: resolved branch type, taken flag and miss flag.
- Sits at fetch/decode and keeps hit/miss statistics counters for debug.

---
 rtl/branch_pkg.sv | 38 +++
 rtl/sat_counter2.sv | 26 ++
 rtl/branch_predictor.sv | 105 ++++++++++
 tb/tb_branch_predictor.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared branch definitions: type codes, counter constants and the
// conditional/unconditional classification used by predict and resolve.
package branch_pkg;

  typedef enum logic [3:0] {
    BT_NONE  = 4'h0,
    BT_BRCC  = 4'h1,
    BT_BRCS  = 4'h2,
    BT_BREQ  = 4'h3,
    BT_BRN   = 4'h4,
    BT_BRNE  = 4'h5,
    BT_CALL  = 4'h6,
    BT_RET   = 4'h7,
    BT_RETID = 4'h8,
    BT_RETIE = 4'h9
  } branch_type_t;

  localparam logic [1:0] CNT_RESET = 2'b01;
  localparam logic [1:0] CNT_MAX   = 2'b11;
  localparam logic [1:0] CNT_MIN   = 2'b00;

  // Branches whose direction is data dependent and therefore trained.
  function automatic logic is_conditional(branch_type_t t);
    case (t)
      BT_BRCC, BT_BRCS, BT_BREQ, BT_BRNE: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Branches that always redirect; codes A-F fall into the default.
  function automatic logic is_unconditional(branch_type_t t);
    case (t)
      BT_BRN, BT_CALL, BT_RET, BT_RETID, BT_RETIE: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Single 2-bit saturating counter, one table entry of the predictor.
module sat_counter2
  import branch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt
);

  // Count up or down when enabled, clamping at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= CNT_RESET;
    end else if (en) begin
      if (inc && (cnt != CNT_MAX)) begin
        cnt <= cnt + 2'd1;
      end else if (dec && (cnt != CNT_MIN)) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with 2-bit counters and hit/miss statistics.
// Optional gshare indexing is enabled with BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor
  import branch_pkg::*;
#(
  parameter int PC_W   = 10,
  parameter int IDX_W  = 6,
  parameter int STAT_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              PRED_VALID,
  input  logic [PC_W-1:0]   PRED_PC,
  input  logic [3:0]        PRED_BRANCH_TYPE,
  output logic              BRANCH_PREDICTED,
  output logic [IDX_W-1:0]  PRED_IDX,
  input  logic              RES_VALID,
  input  logic [3:0]        RES_BRANCH_TYPE,
  input  logic [IDX_W-1:0]  RES_IDX,
  input  logic              RES_TAKEN,
  input  logic              RES_MISS,
  output logic [STAT_W-1:0] PRED_COUNT,
  output logic [STAT_W-1:0] MISS_COUNT
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       cnt [DEPTH];
  logic             upd;
  logic [IDX_W-1:0] lookup_idx;
  logic             pred_next;
  logic             unused_pc;

  assign unused_pc = ^PRED_PC[PC_W-1:IDX_W];
  assign upd       = RES_VALID && is_conditional(branch_type_t'(RES_BRANCH_TYPE));

  // One counter per table entry; only the entry named by the resolve index moves.
  for (genvar i = 0; i < DEPTH; i++) begin : g_table
    sat_counter2 u_cnt (
      .clk (CLK),
      .rst (RST),
      .en  (upd && (RES_IDX == IDX_W'(i))),
      .inc (RES_TAKEN),
      .dec (!RES_TAKEN),
      .cnt (cnt[i])
    );
  end

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_W-1:0] ghr;

  // Non-speculative global history, shifted only on conditional resolution.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ghr <= '0;
    end else if (upd) begin
      ghr <= {ghr[IDX_W-2:0], RES_TAKEN};
    end
  end

  assign lookup_idx = PRED_PC[IDX_W-1:0] ^ ghr;
`else
  assign lookup_idx = PRED_PC[IDX_W-1:0];
`endif

  // Prediction from the pre-update table contents (no write bypass).
  always_comb begin
    pred_next = 1'b0;
    if (PRED_VALID) begin
      if (is_conditional(branch_type_t'(PRED_BRANCH_TYPE))) begin
        pred_next = cnt[lookup_idx][1];
      end else if (is_unconditional(branch_type_t'(PRED_BRANCH_TYPE))) begin
        pred_next = 1'b1;
      end
    end
  end

  // Predict-side output register, frozen while the pipe is stalled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BRANCH_PREDICTED <= 1'b0;
      PRED_IDX         <= '0;
    end else if (!STALL) begin
      BRANCH_PREDICTED <= pred_next;
      PRED_IDX         <= lookup_idx;
    end
  end

  // Saturating debug statistics for resolved conditional branches.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PRED_COUNT <= '0;
      MISS_COUNT <= '0;
    end else if (upd) begin
      if (PRED_COUNT != '1) begin
        PRED_COUNT <= PRED_COUNT + STAT_W'(1);
      end
      if (RES_MISS && (MISS_COUNT != '1)) begin
        MISS_COUNT <= MISS_COUNT + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor with a reference model and an
// expected-output queue; honours BRANCH_PREDICTOR_GSHARE_EN.
module tb_branch_predictor;

  localparam int PC_W   = 10;
  localparam int IDX_W  = 6;
  localparam int STAT_W = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic              STALL;
  logic              PRED_VALID;
  logic [PC_W-1:0]   PRED_PC;
  logic [3:0]        PRED_BRANCH_TYPE;
  logic              BRANCH_PREDICTED;
  logic [IDX_W-1:0]  PRED_IDX;
  logic              RES_VALID;
  logic [3:0]        RES_BRANCH_TYPE;
  logic [IDX_W-1:0]  RES_IDX;
  logic              RES_TAKEN;
  logic              RES_MISS;
  logic [STAT_W-1:0] PRED_COUNT;
  logic [STAT_W-1:0] MISS_COUNT;

  branch_predictor #(.PC_W(PC_W), .IDX_W(IDX_W), .STAT_W(STAT_W)) dut (
    .CLK              (CLK),
    .RST              (RST),
    .STALL            (STALL),
    .PRED_VALID       (PRED_VALID),
    .PRED_PC          (PRED_PC),
    .PRED_BRANCH_TYPE (PRED_BRANCH_TYPE),
    .BRANCH_PREDICTED (BRANCH_PREDICTED),
    .PRED_IDX         (PRED_IDX),
    .RES_VALID        (RES_VALID),
    .RES_BRANCH_TYPE  (RES_BRANCH_TYPE),
    .RES_IDX          (RES_IDX),
    .RES_TAKEN        (RES_TAKEN),
    .RES_MISS         (RES_MISS),
    .PRED_COUNT       (PRED_COUNT),
    .MISS_COUNT       (MISS_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             pred;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t       sb[$];
  exp_t       held;
  int         checks   = 0;
  int         failures = 0;
  logic [1:0] m_cnt [64];
  int         m_pc;
  int         m_mc;
  logic [IDX_W-1:0] m_ghr;

  function automatic logic m_cond(logic [3:0] t);
    return (t == 4'd1) || (t == 4'd2) || (t == 4'd3) || (t == 4'd5);
  endfunction

  function automatic logic m_uncond(logic [3:0] t);
    return (t == 4'd4) || (t >= 4'd6 && t <= 4'd9);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 2'b01;
    m_pc  = 0;
    m_mc  = 0;
    m_ghr = '0;
    held  = '0;
  endtask

  // One clock of stimulus: model predicts, pushes expectation, DUT output popped after the edge.
  task automatic step(input logic stall, input logic pv, input logic [PC_W-1:0] pc,
                      input logic [3:0] pt, input logic rv, input logic [3:0] rt,
                      input logic [IDX_W-1:0] ridx, input logic rtk, input logic rms);
    exp_t             e;
    logic [IDX_W-1:0] li;
    STALL = stall; PRED_VALID = pv; PRED_PC = pc; PRED_BRANCH_TYPE = pt;
    RES_VALID = rv; RES_BRANCH_TYPE = rt; RES_IDX = ridx; RES_TAKEN = rtk; RES_MISS = rms;
    li = pc[IDX_W-1:0];
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    li = li ^ m_ghr;
`endif
    e.idx  = li;
    e.pred = pv ? (m_cond(pt) ? m_cnt[li][1] : m_uncond(pt)) : 1'b0;
    if (!stall) held = e;
    sb.push_back(held);
    if (rv && m_cond(rt)) begin
      if (rtk && m_cnt[ridx] != 2'b11) m_cnt[ridx] = m_cnt[ridx] + 2'd1;
      if (!rtk && m_cnt[ridx] != 2'b00) m_cnt[ridx] = m_cnt[ridx] - 2'd1;
      if (m_pc < 'hFFFF) m_pc++;
      if (rms && m_mc < 'hFFFF) m_mc++;
      m_ghr = {m_ghr[IDX_W-2:0], rtk};
    end
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk("branch_predicted", 32'(BRANCH_PREDICTED), 32'(e.pred));
    chk("pred_idx", 32'(PRED_IDX), 32'(e.idx));
    chk("pred_count", 32'(PRED_COUNT), m_pc);
    chk("miss_count", 32'(MISS_COUNT), m_mc);
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc, input logic [3:0] pt);
    step(1'b0, 1'b1, pc, pt, 1'b0, 4'd0, '0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [3:0] rt, input logic [IDX_W-1:0] ridx,
                         input logic tk, input logic ms);
    step(1'b0, 1'b0, '0, 4'd0, 1'b1, rt, ridx, tk, ms);
  endtask

  initial begin
    RST = 1'b1; STALL = 0; PRED_VALID = 0; PRED_PC = '0; PRED_BRANCH_TYPE = '0;
    RES_VALID = 0; RES_BRANCH_TYPE = '0; RES_IDX = '0; RES_TAKEN = 0; RES_MISS = 0;
    model_reset();
    #12;
    chk("rst_pred", 32'(BRANCH_PREDICTED), 0);
    chk("rst_idx", 32'(PRED_IDX), 0);
    chk("rst_pred_count", 32'(PRED_COUNT), 0);
    chk("rst_miss_count", 32'(MISS_COUNT), 0);
    RST = 1'b0;

    // Weakly not-taken after reset, then train up, saturate, and train down.
    lookup(10'h005, 4'd3);
    repeat (2) resolve(4'd3, 6'd5, 1'b1, 1'b0);
    lookup(10'h005, 4'd3);
    repeat (3) resolve(4'd3, 6'd5, 1'b1, 1'b1);
    lookup(10'h005, 4'd3);
    repeat (4) resolve(4'd3, 6'd5, 1'b0, 1'b1);
    lookup(10'h005, 4'd3);

    // Unconditional, unused and invalid lookups; unconditional resolutions leave the table alone.
    lookup(10'h005, 4'd4);
    lookup(10'h005, 4'd6);
    lookup(10'h005, 4'd9);
    lookup(10'h005, 4'hA);
    lookup(10'h005, 4'd0);
    step(1'b0, 1'b0, 10'h005, 4'd4, 1'b0, 4'd0, '0, 1'b0, 1'b0);
    repeat (2) resolve(4'd6, 6'd5, 1'b0, 1'b1);
    repeat (2) resolve(4'd6, 6'd5, 1'b1, 1'b1);
    repeat (2) resolve(4'hB, 6'd5, 1'b1, 1'b1);
    lookup(10'h005, 4'd3);

    // Same-cycle lookup and update of one entry reads the old counter.
    step(1'b0, 1'b1, 10'h007, 4'd1, 1'b1, 4'd1, 6'd7, 1'b1, 1'b0);
    lookup(10'h007, 4'd1);

    // Outputs frozen under stall while an update still lands.
    step(1'b1, 1'b1, 10'h03F, 4'd4, 1'b1, 4'd1, 6'd7, 1'b1, 1'b0);
    step(1'b1, 1'b1, 10'h03F, 4'd4, 1'b0, 4'd0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 10'h012, 4'd2, 1'b0, 4'd0, '0, 1'b0, 1'b0);
    resolve(4'd1, 6'd7, 1'b0, 1'b0);
    lookup(10'h007, 4'd1);

    // Statistics saturation: run past all-ones with every resolution a miss.
    STALL = 0; PRED_VALID = 1; PRED_PC = 10'h02A; PRED_BRANCH_TYPE = 4'd4;
    RES_VALID = 1; RES_BRANCH_TYPE = 4'd1; RES_IDX = 6'd0; RES_TAKEN = 1; RES_MISS = 1;
    repeat (65538) @(posedge CLK);
    #1;
    m_cnt[0] = 2'b11;
    m_pc = 'hFFFF;
    m_mc = 'hFFFF;
    held.pred = 1'b1;
    held.idx  = 6'h2A;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    m_ghr    = '1;
    held.idx = 6'h2A ^ m_ghr;
`endif
    chk("sat_pred", 32'(BRANCH_PREDICTED), 32'(held.pred));
    chk("sat_idx", 32'(PRED_IDX), 32'(held.idx));
    chk("sat_pred_count", 32'(PRED_COUNT), 32'hFFFF);
    chk("sat_miss_count", 32'(MISS_COUNT), 32'hFFFF);

    // Asynchronous reset between clock edges.
    #2;
    RST = 1'b1;
    #1;
    chk("arst_pred", 32'(BRANCH_PREDICTED), 0);
    chk("arst_idx", 32'(PRED_IDX), 0);
    chk("arst_pred_count", 32'(PRED_COUNT), 0);
    chk("arst_miss_count", 32'(MISS_COUNT), 0);
    RES_VALID = 0; PRED_VALID = 0;
    #2;
    RST = 1'b0;
    model_reset();
    lookup(10'h000, 4'd1);

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    resolve(4'd1, 6'd0, 1'b1, 1'b0);
    resolve(4'd1, 6'd0, 1'b1, 1'b0);
    resolve(4'd1, 6'd0, 1'b0, 1'b0);
    lookup(10'h003, 4'd1);
    chk("gshare_idx", 32'(PRED_IDX), 32'h05);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
